rom_dl_arbiter: RTL

- Owns the single-port program/graphics ROM RAM that sits behind the game core.
- Shares that RAM between two requesters: HPS ioctl download writes and core-side runtime reads.
- Sequences core reset around downloads: the core is held in reset until a download completes, then for a programmable stretch afterwards.
- Sits between hps_io and the game core in the emu top level.

---
 rtl/rom_dl_pkg.sv | 24 ++
 rtl/rom_dl_arbiter_rst_stretch_timer.sv | 27 ++
 rtl/rom_dl_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rom_dl_pkg.sv
// Shared types and default sizing for the ROM download arbiter.
package rom_dl_pkg;

    localparam int unsigned AW_DEF        = 19;
    localparam int unsigned DW_DEF        = 8;
    localparam int unsigned ROM_BYTES_DEF = 32'h40000;
    localparam int unsigned RST_HOLD_DEF  = 16;
    localparam int unsigned DL_CNT_W      = 20;

    typedef enum logic [1:0] {
        S_HOLD,
        S_DL,
        S_POST,
        S_RUN
    } dl_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_ACK
    } rd_stage_e;

endpackage

// File: rtl/rom_dl_arbiter_rst_stretch_timer.sv
// Loadable down-counter that times the core-reset stretch after a download.
module rst_stretch_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/rom_dl_arbiter.sv
// Shares the ROM RAM between HPS download writes and core reads, and holds
// the core in reset across downloads plus a fixed stretch afterwards.
module rom_dl_arbiter
    import rom_dl_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned ROM_BYTES = ROM_BYTES_DEF,
    parameter int unsigned RST_HOLD  = RST_HOLD_DEF
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [AW-1:0]       ioctl_addr,
    input  logic [DW-1:0]       ioctl_dout,
    input  logic                core_rd_req,
    input  logic [AW-1:0]       core_addr,
    output logic                core_rd_ack,
    output logic [DW-1:0]       core_rd_data,
    output logic                core_reset,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_we,
    output logic [DW-1:0]       mem_din,
    input  logic [DW-1:0]       mem_dout,
    output logic [DL_CNT_W-1:0] dl_bytes,
    output logic                oob_err
);

    localparam int unsigned TW  = $clog2(RST_HOLD) + 1;
    localparam int unsigned AW1 = AW + 1;
    // One extra bit so ROM_BYTES = 2^AW accepts every address.
    localparam logic [AW:0] ROM_LIMIT = AW1'(ROM_BYTES);

    dl_state_e             state, state_d;
    rd_stage_e             rd_stage, rd_stage_d;
    logic                  rd_guard, rd_guard_d;
    logic                  core_rd_ack_d, core_reset_d, mem_we_d, oob_err_d;
    logic [DW-1:0]         core_rd_data_d, mem_din_d;
    logic [AW-1:0]         mem_addr_d;
    logic [DL_CNT_W-1:0]   dl_bytes_d;
    logic                  dl_entry, wr_hit, wr_ok, rd_grant;
    logic                  timer_load, timer_dec, timer_zero_c;

    assign timer_load = (state == S_DL) && !ioctl_download;
    assign timer_dec  = (state == S_POST);

    rst_stretch_timer #(
        .W(TW)
    ) u_timer (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .load     (timer_load),
        .load_val (TW'(RST_HOLD - 1)),
        .dec      (timer_dec),
        .zero_c   (timer_zero_c)
    );

    // State and registered outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= S_HOLD;
            rd_stage     <= R_IDLE;
            rd_guard     <= 1'b0;
            core_reset   <= 1'b1;
            core_rd_ack  <= 1'b0;
            core_rd_data <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_din      <= '0;
            dl_bytes     <= '0;
            oob_err      <= 1'b0;
        end else begin
            state        <= state_d;
            rd_stage     <= rd_stage_d;
            rd_guard     <= rd_guard_d;
            core_reset   <= core_reset_d;
            core_rd_ack  <= core_rd_ack_d;
            core_rd_data <= core_rd_data_d;
            mem_addr     <= mem_addr_d;
            mem_we       <= mem_we_d;
            mem_din      <= mem_din_d;
            dl_bytes     <= dl_bytes_d;
            oob_err      <= oob_err_d;
        end
    end

    // Next state; a rising download wins from every state
    always_comb begin
        state_d = state;
        case (state)
            S_HOLD:  if (ioctl_download) state_d = S_DL;
            S_DL:    if (!ioctl_download) state_d = S_POST;
            S_POST: begin
                if (ioctl_download)   state_d = S_DL;
                else if (timer_zero_c) state_d = S_RUN;
            end
            S_RUN:   if (ioctl_download) state_d = S_DL;
            default: state_d = S_HOLD;
        endcase
    end

    // Next values of the registered outputs and read pipeline
    always_comb begin
        dl_entry = (state_d == S_DL) && (state != S_DL);
        wr_hit   = (state == S_DL) && ioctl_wr;
        wr_ok    = wr_hit && ({1'b0, ioctl_addr} < ROM_LIMIT);
        rd_grant = (state == S_RUN) && (rd_stage == R_IDLE) && !rd_guard
                   && core_rd_req && !dl_entry;

        rd_stage_d     = rd_stage;
        rd_guard_d     = 1'b0;
        core_reset_d   = (state_d != S_RUN);
        core_rd_ack_d  = 1'b0;
        core_rd_data_d = core_rd_data;
        mem_addr_d     = mem_addr;
        mem_we_d       = 1'b0;
        mem_din_d      = mem_din;
        dl_bytes_d     = dl_bytes;
        oob_err_d      = oob_err;

        if (dl_entry) begin
            rd_stage_d = R_IDLE;
            dl_bytes_d = '0;
            oob_err_d  = 1'b0;
        end else begin
            if (wr_ok) begin
                mem_we_d   = 1'b1;
                mem_addr_d = ioctl_addr;
                mem_din_d  = ioctl_dout;
                if (dl_bytes != '1) dl_bytes_d = dl_bytes + DL_CNT_W'(1);
            end else if (wr_hit) begin
                oob_err_d = 1'b1;
            end

            // rd_guard blanks the cycle after ack so a held req is not re-granted
            case (rd_stage)
                R_IDLE: begin
                    if (rd_grant) begin
                        rd_stage_d = R_ADDR;
                        mem_addr_d = core_addr;
                    end
                end
                R_ADDR: rd_stage_d = R_DATA;
                R_DATA: begin
                    rd_stage_d     = R_ACK;
                    core_rd_ack_d  = 1'b1;
                    core_rd_data_d = mem_dout;
                end
                R_ACK: begin
                    rd_stage_d = R_IDLE;
                    rd_guard_d = 1'b1;
                end
                default: rd_stage_d = R_IDLE;
            endcase
        end
    end

endmodule
